// File: rtl/bus_protocol_pkg.sv
// Shared types and constants for the dValid/dAck byte-bus target.
package bus_protocol_pkg;

    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ACK_MAX = 3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACK,
        DONE
    } state_t;

endpackage

// File: rtl/bus_protocol_fifo.sv
// Show-ahead FIFO: the head entry is presented whenever the FIFO is not empty.
// A push while full is accepted only when a pop happens in the same cycle.
module bus_protocol_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       count;
    logic              do_push;
    logic              do_pop;

    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty and wraps freely.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; a write during reset is harmless since wr_ptr does not advance.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/bus_protocol_target.sv
// Target end of the dValid/dAck byte bus: edge-detects each transfer, returns
// a one-cycle registered dAck, and buffers the byte in a show-ahead FIFO.
// Optional build macro BUS_TARGET_ERR_EN compiles in the sticky error flags;
// without it err_abort/err_hold/err_overflow are tied low.
module bus_protocol_target
    import bus_protocol_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ACK_DELAY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dValid,
    input  logic [DATA_W-1:0] data,
    output logic              dAck,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err_abort,
    output logic              err_hold,
    output logic              err_overflow
);

    localparam logic [1:0] ACK_D = 2'(ACK_DELAY);
    localparam logic [1:0] ACK_M = 2'(ACK_MAX);

    state_t     state;
    logic [1:0] cnt;
    logic [1:0] next_cnt;
    logic       go_ack;
    logic       dValid_q;
    logic       start;
    logic       fifo_full;
    logic       fifo_empty;
    logic       push;

    assign start     = dValid && !dValid_q;
    assign push      = (state == ACK);
    assign out_valid = !fifo_empty;

    // next_cnt is the cycle index (relative to start) that the coming edge opens;
    // dAck is registered, so the decision for cycle d is taken at the end of d-1.
    assign next_cnt = (state == IDLE) ? 2'd1 : cnt + 2'd1;
    assign go_ack   = ((next_cnt >= ACK_D) && !fifo_full) || (next_cnt == ACK_M);

    // Previous dValid; resets high so a transfer in flight at reset is ignored.
    always_ff @(posedge clk) begin
        if (reset) dValid_q <= 1'b1;
        else       dValid_q <= dValid;
    end

    // Transfer FSM with registered dAck.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            dAck  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= 2'd1;
                        if (go_ack) begin
                            state <= ACK;
                            dAck  <= 1'b1;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!dValid) begin
                        state <= IDLE;
                    end else if (go_ack) begin
                        state <= ACK;
                        dAck  <= 1'b1;
                    end else begin
                        cnt <= next_cnt;
                    end
                end
                ACK: begin
                    dAck  <= 1'b0;
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    dAck  <= 1'b0;
                end
            endcase
        end
    end

    bus_protocol_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef BUS_TARGET_ERR_EN
    logic abort_evt;
    logic hold_evt;
    logic ovf_evt;

    assign abort_evt = (state == WAIT) && !dValid;
    assign hold_evt  = (state == DONE) && dValid;
    assign ovf_evt   = (state == ACK) && fifo_full && !(out_ready && out_valid);

    // Sticky protocol-violation flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_abort    <= 1'b0;
            err_hold     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            if (abort_evt) err_abort    <= 1'b1;
            if (hold_evt)  err_hold     <= 1'b1;
            if (ovf_evt)   err_overflow <= 1'b1;
        end
    end
`else
    assign err_abort    = 1'b0;
    assign err_hold     = 1'b0;
    assign err_overflow = 1'b0;
`endif

endmodule
